uart_rx_frame: RTL
==================

// Module: uart_rx_frame
// PURPOSE
//  Parametrised UART receiver and the successor to the fixed 8N1 receiver. Accepts 5..9 data bits,
//  1 or 2 stop bits and optional parity, and takes each bit as a 3-sample majority vote.
//  Reports framing and parity errors alongside each received word.
//  Sits between the host serial pin and the scope command decoder, one instance per serial link.
// PARAMETERS
//  CLKS_PER_BIT      868  i_Clock cycles per UART bit (100 MHz / 115200). Must be >= 8.
//  CLK_COUNTER_BITS  10   bit-timer width. Must hold CLKS_PER_BIT-1.
//  DATA_BITS         8    data bits per frame, 5..9, sent LSB first.
//  STOP_BITS         1    stop bits checked per frame, 1 or 2.
//  PARITY_ODD        0    0 = even parity, 1 = odd. Only used with UART_RX_PARITY_EN.
// PORTS
//  i_Clock       in   1          system clock
//  i_Reset       in   1          asynchronous, active-high reset
//  i_Rx_Serial   in   1          asynchronous serial line, idles high
//  o_Rx_DV       out  1          one-cycle strobe: word and flags valid
//  o_Rx_Byte     out  DATA_BITS  received word, held until next o_Rx_DV
//  o_Frame_Err   out  1          a stop bit was sampled 0. Valid with o_Rx_DV, then held.
//  o_Parity_Err  out  1          parity mismatch. Valid with o_Rx_DV, then held.
//  o_Busy        out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset (async, i_Reset=1)
//  - both sync flops go to 1, state goes to IDLE, counters go to 0.
//  - o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err and o_Busy all go to 0.
//  - Reset mid-frame abandons the frame; no o_Rx_DV is issued for it.
//  Input synchronisation: i_Rx_Serial passes through 2 flops; only the synced signal rx_s is used.
//  Bit timer
//  - cnt runs 0..CLKS_PER_BIT-1 per bit period. It wraps to 0 and moves to the next bit at CLKS_PER_BIT-1.
//  - Let M = (CLKS_PER_BIT-1)/2. rx_s is sampled at cnt = M-1, M and M+1.
//  - The bit value is the majority of the 3 samples, decided at cnt = M+1.
//  States
//  - IDLE: when rx_s==0, cnt is set to 0 in that cycle and the block goes to START.
//  - START: if the majority is 1 (false start), return to IDLE with no strobe. Otherwise go to DATA at the period end.
//  - DATA: DATA_BITS bits, stored LSB first into a shift/index register. Bit index width is $clog2(DATA_BITS).
//    After the last bit, go to PARITY if the macro is defined, else to STOP.
//  - PARITY: the decided bit is XORed with the data. Error when the result != PARITY_ODD.
//  - STOP: each stop bit is checked and any 0 sets the frame error.
//    With STOP_BITS=2, the first stop bit runs its full period.
//    The final stop bit ends at its decision point (cnt = M+1), not at the period end, so back-to-back start edges are not missed.
//  - DONE (1 cycle): o_Rx_DV=1 and o_Rx_Byte, o_Frame_Err and o_Parity_Err are loaded together.
//    Next state is IDLE if the frame is good, else WAIT_HIGH.
//  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break (line held low) yields exactly one o_Rx_DV.
//  Latency: o_Rx_DV rises 1 cycle after the last stop-bit decision.
//  Outputs and flags never change between strobes.
//  Unreachable state encodings go to IDLE.
// CONFIGURATION
//  UART_RX_PARITY_EN
//  - Defined: a parity bit is expected between the data bits and the stop bits; o_Parity_Err is live.
//  - Undefined: no parity bit in the frame, PARITY state removed, o_Parity_Err tied 0, PARITY_ODD ignored.
// TESTING (CLKS_PER_BIT=16, M=7, DATA_BITS=8, STOP_BITS=1 unless stated)
//  1. Send 8N1 0xA5, then 0x5A back-to-back with 1 stop bit.
//     -> two single-cycle o_Rx_DV pulses; bytes 0xA5 then 0x5A; both error flags 0.
//  2. Pull the line low 4 cycles, then high.
//     -> no o_Rx_DV; o_Busy drops within 1 bit time; a following frame 0x3C is received correctly.
//  3. Send 1-cycle low glitches at cnt=M in data bits 0 and 3 of 0xFF.
//     -> majority rejects them; byte 0xFF, no errors.
//  4. Send 0x3C with stop=0, then hold the line low 40 bit times, then idle.
//     -> exactly one o_Rx_DV with o_Frame_Err=1 and byte 0x3C; next 0x81 is received cleanly with o_Frame_Err=0.
//  5. UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 0.
//     -> o_Parity_Err=1. With parity bit 1 -> o_Parity_Err=0. Repeat with PARITY_ODD=1: opposite results.
//  6. Assert i_Reset at data bit 4 of 0xC3.
//     -> all outputs 0 immediately, no strobe; after release, 0x96 is received correctly.
//     Also run DATA_BITS=7, STOP_BITS=2 with 0x55 -> byte 0x55.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with 3-sample majority voting per bit.
// Frame: start bit, 5..9 data bits (LSB first), optional parity bit, 1 or 2 stop bits.
// Optional feature macro: UART_RX_PARITY_EN adds the parity bit and enables o_Parity_Err.
// Ports:
//   i_Clock      system clock
//   i_Reset      asynchronous active-high reset
//   i_Rx_Serial  asynchronous serial line, idles high
//   o_Rx_DV      one-cycle strobe, word and flags valid
//   o_Rx_Byte    received word, held until the next strobe
//   o_Frame_Err  a stop bit was sampled low (valid with strobe, then held)
//   o_Parity_Err parity mismatch (valid with strobe, then held; 0 without parity)
//   o_Busy       high whenever the receiver is not idle
module uart_rx_frame #(
    parameter int CLKS_PER_BIT     = 868,
    parameter int CLK_COUNTER_BITS = 10,
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int PARITY_ODD       = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Busy
);
    localparam int M  = (CLKS_PER_BIT - 1) / 2;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CLK_COUNTER_BITS-1:0] C_S0  = CLK_COUNTER_BITS'(M - 1);
    localparam logic [CLK_COUNTER_BITS-1:0] C_S1  = CLK_COUNTER_BITS'(M);
    localparam logic [CLK_COUNTER_BITS-1:0] C_DEC = CLK_COUNTER_BITS'(M + 1);
    localparam logic [CLK_COUNTER_BITS-1:0] C_END = CLK_COUNTER_BITS'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic PODD = PARITY_ODD[0];
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY     = 3'd6;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic [1:0]                  sync;
    logic                        rx_s, s0, s1, maj, dec, wrap, last_stop, stop_idx, ferr;
    logic [2:0]                  state;
    logic [CLK_COUNTER_BITS-1:0] cnt;
    logic [IW-1:0]               bit_idx;
    logic [DATA_BITS-1:0]        shreg;
`ifdef UART_RX_PARITY_EN
    logic                        perr;
`endif

    assign rx_s      = sync[1];
    // Third vote is the live sample taken at the decision point itself.
    assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign dec       = cnt == C_DEC;
    assign wrap      = cnt == C_END;
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    assign o_Busy    = state != IDLE;
`ifndef UART_RX_PARITY_EN
    // Without a parity bit PARITY_ODD has no effect and the flag is constant 0.
    assign o_Parity_Err = PODD & 1'b0;
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync        <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            shreg       <= '0;
            ferr        <= 1'b0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Byte   <= '0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr         <= 1'b0;
            o_Parity_Err <= 1'b0;
`endif
        end else begin
            sync    <= {sync[0], i_Rx_Serial};
            o_Rx_DV <= 1'b0;
            cnt     <= wrap ? '0 : cnt + 1'b1;
            if (cnt == C_S0) s0 <= rx_s;
            if (cnt == C_S1) s1 <= rx_s;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr     <= 1'b0;
`endif
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (dec && maj) state <= IDLE;
                    else if (wrap) state <= DATA;
                end
                DATA: begin
                    if (dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (wrap) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) state <= AFTER_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (dec) perr <= (^{shreg, maj}) != PODD;
                    if (wrap) state <= STOP;
                end
`endif
                STOP: begin
                    if (dec && !maj) ferr <= 1'b1;
                    // The final stop bit ends at its decision point so an
                    // immediately following start edge is still caught.
                    if (dec && last_stop) begin
                        state       <= DONE;
                        o_Rx_DV     <= 1'b1;
                        o_Rx_Byte   <= shreg;
                        o_Frame_Err <= ferr | ~maj;
`ifdef UART_RX_PARITY_EN
                        o_Parity_Err <= perr;
`endif
                    end
                    if (wrap) stop_idx <= 1'b1;
                end
                DONE: state <= ferr ? WAIT_HIGH : IDLE;
                WAIT_HIGH: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
